// File: rtl/act_ldr_pkg.sv
// Shared types for the activation SRAM loader.
// Optional stall counter: ACT_LDR_PERF_CNT_EN.
package act_ldr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } ldr_state_t;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/act_ldr_skid.sv
// One-entry skid register catching SRAM data
// that returns while the FIFO bank is full.
module act_ldr_skid
  import act_ldr_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         unload,
  input  logic [W-1:0] data,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= data;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/act_sram_loader.sv
// Streams activation vectors from SRAM into the input FIFO bank.
// Define ACT_LDR_PERF_CNT_EN to add the stall_cnt port.
module act_sram_loader
  import act_ldr_pkg::*;
#(
  parameter int col    = 8,
  parameter int bw     = 4,
  parameter int addr_w = 11,
  parameter int len_w  = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [addr_w-1:0] base_addr,
  input  logic [len_w-1:0]  num_vec,
  output logic              busy,
  output logic              done,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [addr_w-1:0] sram_addr,
  input  logic [col*bw-1:0] sram_q,
  input  logic              ififo_ready,
  output logic              ififo_wr,
  output logic [col*bw-1:0] ififo_in
`ifdef ACT_LDR_PERF_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam int W = col * bw;

  ldr_state_t        state;
  logic [addr_w-1:0] base_r;
  logic [len_w-1:0]  num_r;
  logic [len_w-1:0]  issue_cnt;
  logic [len_w-1:0]  issue_nxt;
  logic              issue;
  logic              last_issue;
  logic              rd_valid;
  logic              skid_valid;
  logic              skid_load;
  logic              skid_unload;
  logic              wr_direct;
  logic [W-1:0]      skid_q;

  assign sram_wen   = 1'b1;
  assign issue      = (state == RUN) & ififo_ready
                    & ~skid_valid & (issue_cnt < num_r);
  assign sram_cen   = ~issue;
  assign sram_addr  = base_r + addr_w'(issue_cnt);
  assign issue_nxt  = issue_cnt + len_w'(1);
  assign last_issue = issue & (issue_nxt == num_r);

  // Skid drains before new SRAM data, keeping address order.
  assign skid_unload = skid_valid & ififo_ready;
  assign wr_direct   = rd_valid & ififo_ready & ~skid_valid;
  assign skid_load   = rd_valid & ~ififo_ready;
  assign ififo_wr    = skid_unload | wr_direct;

  always_comb begin
    ififo_in = '0;
    unique case (1'b1)
      skid_unload: ififo_in = skid_q;
      wr_direct:   ififo_in = sram_q;
      default:     ififo_in = '0;
    endcase
  end

  act_ldr_skid #(
    .W(W)
  ) u_skid (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (skid_load),
    .unload (skid_unload),
    .data   (sram_q),
    .valid  (skid_valid),
    .q      (skid_q)
  );

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // DRAIN exits on the cycle its last pending word is written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      base_r    <= '0;
      num_r     <= '0;
      issue_cnt <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= issue;
      if (issue) issue_cnt <= issue_nxt;
      unique case (state)
        IDLE: begin
          if (start) begin
            base_r    <= base_addr;
            num_r     <= num_vec;
            issue_cnt <= '0;
            state     <= (num_vec == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (last_issue || issue_cnt == num_r)
            state <= DRAIN;
        end
        DRAIN: begin
          if (ififo_ready || (!rd_valid && !skid_valid))
            state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ACT_LDR_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (state == IDLE && start) begin
      stall_cnt <= '0;
    end else if ((state == RUN || state == DRAIN)
                 && !ififo_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule
